// File: rtl/memory_access_stage.sv
// RV32I MEM stage: dcache handshake, store alignment,
// load extraction and the MEM/WB pipeline register.
package rv32i_types;
  typedef logic [31:0] rv32i_word;

  localparam logic [6:0] op_lui   = 7'b0110111;
  localparam logic [6:0] op_auipc = 7'b0010111;
  localparam logic [6:0] op_jal   = 7'b1101111;
  localparam logic [6:0] op_jalr  = 7'b1100111;
  localparam logic [6:0] op_br    = 7'b1100011;
  localparam logic [6:0] op_load  = 7'b0000011;
  localparam logic [6:0] op_store = 7'b0100011;
  localparam logic [6:0] op_imm   = 7'b0010011;
  localparam logic [6:0] op_reg   = 7'b0110011;
  localparam logic [6:0] op_csr   = 7'b1110011;

  typedef struct packed {
    logic [6:0] opcode;
    logic       load_regfile;
    logic [4:0] rd;
  } rv32i_control_word;
endpackage

module memory_access_stage
  import rv32i_types::*;
(
  input  logic              clk,
  input  logic              rst,
  input  rv32i_control_word ctrl_word_in,
  input  logic [31:0]       instruction_in,
  input  logic [31:0]       PC_in,
  input  logic [31:0]       alu_in,
  input  logic [31:0]       rs2_in,
  input  logic              br_en_in,
  input  logic [3:0]        mbe_in,
  input  logic              IF_stall,
  output logic              data_read,
  output logic              data_write,
  output logic [31:0]       data_addr,
  output logic [31:0]       data_wdata,
  output logic [3:0]        data_mbe,
  input  logic [31:0]       data_rdata,
  input  logic              data_resp,
  output logic              MA_stall,
  output rv32i_control_word ctrl_word_out,
  output logic [31:0]       instruction_out,
  output logic [31:0]       PC_out,
  output logic              br_en_out,
  output logic [31:0]       mem_wb_data
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              w_mem_op;
  logic              w_is_ld;
  logic              w_done;
  logic              w_wb_en;
  logic [2:0]        w_funct3;
  logic [4:0]        w_shamt;
  rv32i_word         w_sh;
  rv32i_word         w_ld_data;
  rv32i_word         w_ld_sel;
  rv32i_word         w_wb_data;
  rv32i_word         r_ld_hold;
  rv32i_control_word r_ctrl;
  rv32i_word         r_instr;
  rv32i_word         r_pc;
  logic              r_br_en;
  rv32i_word         r_wb_data;

  assign w_is_ld  = (ctrl_word_in.opcode == op_load);
  assign w_mem_op = w_is_ld ||
                    (ctrl_word_in.opcode == op_store);
  assign w_funct3 = instruction_in[14:12];
  assign w_shamt  = {alu_in[1:0], 3'b000};

  assign data_addr  = {alu_in[31:2], 2'b00};
  assign data_wdata = rs2_in << w_shamt;
  assign data_mbe   = mbe_in;

  assign w_sh = data_rdata >> w_shamt;

  // Extend the selected byte/half/word of the read data by funct3
  always_comb begin
    w_ld_data = w_sh;
    case (w_funct3)
      3'b000:  w_ld_data = {{24{w_sh[7]}}, w_sh[7:0]};
      3'b100:  w_ld_data = {24'b0, w_sh[7:0]};
      3'b001:  w_ld_data = {{16{w_sh[15]}}, w_sh[15:0]};
      3'b101:  w_ld_data = {16'b0, w_sh[15:0]};
      default: w_ld_data = w_sh;
    endcase
  end

  // Next state, cache request and stall; reset kills the request
  always_comb begin
    w_next     = r_state;
    data_read  = 1'b0;
    data_write = 1'b0;
    MA_stall   = 1'b0;
    w_done     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_mem_op) begin
          data_read  = w_is_ld;
          data_write = !w_is_ld;
          if (data_resp) begin
            w_done = 1'b1;
          end else begin
            MA_stall = 1'b1;
            w_next   = BUSY;
          end
        end
      end
      BUSY: begin
        data_read  = w_is_ld;
        data_write = w_mem_op && !w_is_ld;
        if (data_resp) w_done = 1'b1;
        else           MA_stall = 1'b1;
      end
      DONE: begin
        if (!IF_stall) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
    if (w_done) w_next = IF_stall ? DONE : IDLE;
    if (rst) begin
      data_read  = 1'b0;
      data_write = 1'b0;
      MA_stall   = 1'b0;
      w_next     = IDLE;
    end
  end

  // Once in DONE the cache data is gone, so loads use the held copy
  assign w_ld_sel  = (r_state == DONE) ? r_ld_hold : w_ld_data;
  assign w_wb_data = w_is_ld ? w_ld_sel : alu_in;
  assign w_wb_en   = !MA_stall && !IF_stall;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Capture load data when completion coincides with an IF stall
  always_ff @(posedge clk) begin
    if (rst)                      r_ld_hold <= '0;
    else if (w_done && IF_stall)  r_ld_hold <= w_ld_data;
  end

  // MEM/WB pipeline register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl    <= '0;
      r_instr   <= '0;
      r_pc      <= '0;
      r_br_en   <= 1'b0;
      r_wb_data <= '0;
    end else if (w_wb_en) begin
      r_ctrl    <= ctrl_word_in;
      r_instr   <= instruction_in;
      r_pc      <= PC_in;
      r_br_en   <= br_en_in;
      r_wb_data <= w_wb_data;
    end
  end

  assign ctrl_word_out   = r_ctrl;
  assign instruction_out = r_instr;
  assign PC_out          = r_pc;
  assign br_en_out       = r_br_en;
  assign mem_wb_data     = r_wb_data;

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed bench for memory_access_stage:
// handshake timing, extraction, stalls, reset.
module tb_memory_access_stage;
  import rv32i_types::*;

  logic              clk = 1'b0;
  logic              rst;
  rv32i_control_word ctrl_word_in;
  logic [31:0]       instruction_in;
  logic [31:0]       PC_in;
  logic [31:0]       alu_in;
  logic [31:0]       rs2_in;
  logic              br_en_in;
  logic [3:0]        mbe_in;
  logic              IF_stall;
  logic              data_read;
  logic              data_write;
  logic [31:0]       data_addr;
  logic [31:0]       data_wdata;
  logic [3:0]        data_mbe;
  logic [31:0]       data_rdata;
  logic              data_resp;
  logic              MA_stall;
  rv32i_control_word ctrl_word_out;
  logic [31:0]       instruction_out;
  logic [31:0]       PC_out;
  logic              br_en_out;
  logic [31:0]       mem_wb_data;

  int n_vec = 0;
  int n_err = 0;

  rv32i_control_word c_load, c_store, c_add, c_nop;

  memory_access_stage dut (
    .clk(clk), .rst(rst),
    .ctrl_word_in(ctrl_word_in),
    .instruction_in(instruction_in),
    .PC_in(PC_in), .alu_in(alu_in),
    .rs2_in(rs2_in), .br_en_in(br_en_in),
    .mbe_in(mbe_in), .IF_stall(IF_stall),
    .data_read(data_read),
    .data_write(data_write),
    .data_addr(data_addr),
    .data_wdata(data_wdata),
    .data_mbe(data_mbe),
    .data_rdata(data_rdata),
    .data_resp(data_resp),
    .MA_stall(MA_stall),
    .ctrl_word_out(ctrl_word_out),
    .instruction_out(instruction_out),
    .PC_out(PC_out),
    .br_en_out(br_en_out),
    .mem_wb_data(mem_wb_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input rv32i_control_word c,
                        input logic [2:0] f3,
                        input logic [31:0] pc,
                        input logic [31:0] a,
                        input logic [31:0] d,
                        input logic [3:0] m);
    ctrl_word_in   = c;
    instruction_in = {17'b0, f3, 5'b0, c.opcode};
    PC_in          = pc;
    alu_in         = a;
    rs2_in         = d;
    mbe_in         = m;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    IF_stall = 1'b0;
    data_resp = 1'b0;
    data_rdata = '0;
    br_en_in = 1'b1;
    set_in(c_add, 3'b000, 32'h44, 32'h99, 32'h0, 4'h0);
    tick();
    tick();
    n_vec++; if (ctrl_word_out !== c_nop) begin n_err++; $display("FAIL rst_ctrl got %h want %h", ctrl_word_out, c_nop); end
    n_vec++; if (mem_wb_data !== 32'h0) begin n_err++; $display("FAIL rst_wb got %h want 0", mem_wb_data); end
    n_vec++; if (PC_out !== 32'h0) begin n_err++; $display("FAIL rst_pc got %h want 0", PC_out); end
    n_vec++; if (MA_stall !== 1'b0) begin n_err++; $display("FAIL rst_stall got %b want 0", MA_stall); end
    rst = 1'b0;
    br_en_in = 1'b0;
    set_in(c_nop, 3'b000, 32'h0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic test_lw();
    tick();
    set_in(c_load, 3'b010, 32'h1000, 32'h100, 32'h0, 4'hF);
    data_resp = 1'b0;
    #2;
    n_vec++; if (data_read !== 1'b1) begin n_err++; $display("FAIL lw_rd0 got %b want 1", data_read); end
    n_vec++; if (data_addr !== 32'h100) begin n_err++; $display("FAIL lw_addr got %h want 100", data_addr); end
    n_vec++; if (MA_stall !== 1'b1) begin n_err++; $display("FAIL lw_stall0 got %b want 1", MA_stall); end
    tick();
    n_vec++; if (data_read !== 1'b1) begin n_err++; $display("FAIL lw_rd1 got %b want 1", data_read); end
    n_vec++; if (MA_stall !== 1'b1) begin n_err++; $display("FAIL lw_stall1 got %b want 1", MA_stall); end
    n_vec++; if (ctrl_word_out !== c_nop) begin n_err++; $display("FAIL lw_wbhold got %h want %h", ctrl_word_out, c_nop); end
    tick();
    data_resp = 1'b1;
    data_rdata = 32'hDEADBEEF;
    #2;
    n_vec++; if (data_read !== 1'b1) begin n_err++; $display("FAIL lw_rd2 got %b want 1", data_read); end
    n_vec++; if (MA_stall !== 1'b0) begin n_err++; $display("FAIL lw_stall2 got %b want 0", MA_stall); end
    tick();
    data_resp = 1'b0;
    set_in(c_nop, 3'b000, 32'h1004, 32'h0, 32'h0, 4'h0);
    n_vec++; if (mem_wb_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL lw_data got %h want deadbeef", mem_wb_data); end
    n_vec++; if (ctrl_word_out !== c_load) begin n_err++; $display("FAIL lw_ctrl got %h want %h", ctrl_word_out, c_load); end
    n_vec++; if (PC_out !== 32'h1000) begin n_err++; $display("FAIL lw_pc got %h want 1000", PC_out); end
    n_vec++; if (instruction_out !== 32'h00002003) begin n_err++; $display("FAIL lw_instr got %h want 00002003", instruction_out); end
  endtask

  task automatic test_extract();
    logic [2:0]  f3 [3];
    logic [31:0] a  [3];
    logic [31:0] ex [3];
    f3[0] = 3'b000; a[0] = 32'h103; ex[0] = 32'hFFFFFF80;
    f3[1] = 3'b100; a[1] = 32'h103; ex[1] = 32'h00000080;
    f3[2] = 3'b001; a[2] = 32'h102; ex[2] = 32'hFFFF80FF;
    for (int i = 0; i < 3; i++) begin
      tick();
      set_in(c_load, f3[i], 32'h2000, a[i], 32'h0, 4'hF);
      data_resp = 1'b1;
      data_rdata = 32'h80FFFF00;
      #2;
      n_vec++; if (MA_stall !== 1'b0) begin n_err++; $display("FAIL ext_stall%0d got %b want 0", i, MA_stall); end
      tick();
      data_resp = 1'b0;
      set_in(c_nop, 3'b000, 32'h0, 32'h0, 32'h0, 4'h0);
      n_vec++; if (mem_wb_data !== ex[i]) begin n_err++; $display("FAIL ext_data%0d got %h want %h", i, mem_wb_data, ex[i]); end
    end
  endtask

  task automatic test_store();
    tick();
    set_in(c_store, 3'b001, 32'h3000, 32'h202, 32'h1234ABCD, 4'b1100);
    data_resp = 1'b0;
    #2;
    n_vec++; if (data_write !== 1'b1) begin n_err++; $display("FAIL sh_wr0 got %b want 1", data_write); end
    n_vec++; if (data_read !== 1'b0) begin n_err++; $display("FAIL sh_rd got %b want 0", data_read); end
    n_vec++; if (data_addr !== 32'h200) begin n_err++; $display("FAIL sh_addr got %h want 200", data_addr); end
    n_vec++; if (data_wdata !== 32'hABCD0000) begin n_err++; $display("FAIL sh_wdata got %h want abcd0000", data_wdata); end
    n_vec++; if (data_mbe !== 4'b1100) begin n_err++; $display("FAIL sh_mbe got %b want 1100", data_mbe); end
    tick();
    n_vec++; if (data_write !== 1'b1) begin n_err++; $display("FAIL sh_wr1 got %b want 1", data_write); end
    n_vec++; if (MA_stall !== 1'b1) begin n_err++; $display("FAIL sh_stall1 got %b want 1", MA_stall); end
    tick();
    data_resp = 1'b1;
    #2;
    n_vec++; if (MA_stall !== 1'b0) begin n_err++; $display("FAIL sh_stall2 got %b want 0", MA_stall); end
    tick();
    data_resp = 1'b0;
    set_in(c_nop, 3'b000, 32'h40, 32'h0, 32'h0, 4'h0);
    n_vec++; if (ctrl_word_out !== c_store) begin n_err++; $display("FAIL sh_ctrl got %h want %h", ctrl_word_out, c_store); end
    n_vec++; if (mem_wb_data !== 32'h202) begin n_err++; $display("FAIL sh_wb got %h want 202", mem_wb_data); end
  endtask

  task automatic test_if_stall();
    tick();
    n_vec++; if (mem_wb_data !== 32'h0) begin n_err++; $display("FAIL ifs_pre got %h want 0", mem_wb_data); end
    set_in(c_load, 3'b010, 32'h5000, 32'h104, 32'h0, 4'hF);
    IF_stall = 1'b1;
    data_resp = 1'b1;
    data_rdata = 32'h11223344;
    #2;
    n_vec++; if (data_read !== 1'b1) begin n_err++; $display("FAIL ifs_rd0 got %b want 1", data_read); end
    n_vec++; if (MA_stall !== 1'b0) begin n_err++; $display("FAIL ifs_stall0 got %b want 0", MA_stall); end
    for (int i = 0; i < 2; i++) begin
      tick();
      data_rdata = 32'hAAAAAAAA;
      #2;
      n_vec++; if (data_read !== 1'b0) begin n_err++; $display("FAIL ifs_rd_again%0d got %b want 0", i, data_read); end
      n_vec++; if (MA_stall !== 1'b0) begin n_err++; $display("FAIL ifs_stall_done%0d got %b want 0", i, MA_stall); end
      n_vec++; if (PC_out !== 32'h40) begin n_err++; $display("FAIL ifs_hold%0d got %h want 40", i, PC_out); end
    end
    data_resp = 1'b0;
    IF_stall = 1'b0;
    #2;
    n_vec++; if (data_read !== 1'b0) begin n_err++; $display("FAIL ifs_rd_rel got %b want 0", data_read); end
    tick();
    set_in(c_nop, 3'b000, 32'h0, 32'h0, 32'h0, 4'h0);
    n_vec++; if (mem_wb_data !== 32'h11223344) begin n_err++; $display("FAIL ifs_data got %h want 11223344", mem_wb_data); end
    n_vec++; if (PC_out !== 32'h5000) begin n_err++; $display("FAIL ifs_pc got %h want 5000", PC_out); end
    #2;
    n_vec++; if (MA_stall !== 1'b0) begin n_err++; $display("FAIL ifs_idle got %b want 0", MA_stall); end
  endtask

  task automatic test_reset_busy();
    tick();
    set_in(c_load, 3'b010, 32'h6000, 32'h300, 32'h0, 4'hF);
    data_resp = 1'b0;
    tick();
    n_vec++; if (MA_stall !== 1'b1) begin n_err++; $display("FAIL rb_busy got %b want 1", MA_stall); end
    rst = 1'b1;
    #2;
    n_vec++; if (data_read !== 1'b0) begin n_err++; $display("FAIL rb_rd got %b want 0", data_read); end
    n_vec++; if (MA_stall !== 1'b0) begin n_err++; $display("FAIL rb_stall got %b want 0", MA_stall); end
    tick();
    rst = 1'b0;
    set_in(c_nop, 3'b000, 32'h0, 32'h0, 32'h0, 4'h0);
    #2;
    n_vec++; if (ctrl_word_out !== c_nop) begin n_err++; $display("FAIL rb_ctrl got %h want %h", ctrl_word_out, c_nop); end
    n_vec++; if (mem_wb_data !== 32'h0) begin n_err++; $display("FAIL rb_wb got %h want 0", mem_wb_data); end
    n_vec++; if (instruction_out !== 32'h0) begin n_err++; $display("FAIL rb_instr got %h want 0", instruction_out); end
    n_vec++; if (MA_stall !== 1'b0) begin n_err++; $display("FAIL rb_idle got %b want 0", MA_stall); end
  endtask

  task automatic test_back_to_back();
    tick();
    set_in(c_add, 3'b000, 32'h300, 32'h55, 32'h77, 4'h0);
    br_en_in = 1'b1;
    #2;
    n_vec++; if (MA_stall !== 1'b0) begin n_err++; $display("FAIL bb_add_stall got %b want 0", MA_stall); end
    n_vec++; if ({data_read, data_write} !== 2'b00) begin n_err++; $display("FAIL bb_add_req got %b want 00", {data_read, data_write}); end
    tick();
    set_in(c_store, 3'b010, 32'h304, 32'h208, 32'hCAFEF00D, 4'hF);
    br_en_in = 1'b0;
    data_resp = 1'b1;
    n_vec++; if (mem_wb_data !== 32'h55) begin n_err++; $display("FAIL bb_add_wb got %h want 55", mem_wb_data); end
    n_vec++; if (br_en_out !== 1'b1) begin n_err++; $display("FAIL bb_bren got %b want 1", br_en_out); end
    #2;
    n_vec++; if (MA_stall !== 1'b0) begin n_err++; $display("FAIL bb_sw_stall got %b want 0", MA_stall); end
    n_vec++; if (data_wdata !== 32'hCAFEF00D) begin n_err++; $display("FAIL bb_sw_wdata got %h want cafef00d", data_wdata); end
    tick();
    data_resp = 1'b0;
    set_in(c_nop, 3'b000, 32'h0, 32'h0, 32'h0, 4'h0);
    n_vec++; if (ctrl_word_out !== c_store) begin n_err++; $display("FAIL bb_sw_ctrl got %h want %h", ctrl_word_out, c_store); end
    n_vec++; if (PC_out !== 32'h304) begin n_err++; $display("FAIL bb_sw_pc got %h want 304", PC_out); end
    n_vec++; if (mem_wb_data !== 32'h208) begin n_err++; $display("FAIL bb_sw_wb got %h want 208", mem_wb_data); end
  endtask

  initial begin
    c_load  = '{opcode: op_load,  load_regfile: 1'b1, rd: 5'd1};
    c_store = '{opcode: op_store, load_regfile: 1'b0, rd: 5'd0};
    c_add   = '{opcode: op_reg,   load_regfile: 1'b1, rd: 5'd3};
    c_nop   = '0;
    test_reset();
    test_lw();
    test_extract();
    test_store();
    test_if_stall();
    test_reset_busy();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
